// File: rtl/decrypted_ram_writer_if.sv
// -----------------------------------------------------------------------------
// decrypted_ram_writer_if
// Bundles the signals between the decrypted-RAM writer, the RC4 decrypt
// datapath (byte stream), the decrypted-data RAM (write port) and the
// key-search controller (start / status).
//
// Signals:
//   start        controller -> writer   begin a run
//   in_data      datapath   -> writer   decrypted byte
//   in_valid     datapath   -> writer   in_data valid
//   in_ready     writer     -> datapath writer accepts in_data this cycle
//   ram_address  writer     -> RAM      write address
//   ram_data     writer     -> RAM      write data
//   ram_wren     writer     -> RAM      write enable, one-cycle pulse
//   done         writer     -> ctrl     run finished
//   invalid_char writer     -> ctrl     illegal byte seen (valid with done)
//   byte_count   writer     -> ctrl     bytes written in current/last run
//
// Modports:
//   master  the surrounding system (drives start/in_data/in_valid)
//   slave   the writer itself
// -----------------------------------------------------------------------------
interface decrypted_ram_writer_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  start;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] ram_address;
    logic [DATA_WIDTH-1:0] ram_data;
    logic                  ram_wren;
    logic                  done;
    logic                  invalid_char;
    logic [ADDR_WIDTH:0]   byte_count;

    modport master (
        output start, in_data, in_valid,
        input  in_ready, ram_address, ram_data, ram_wren,
               done, invalid_char, byte_count
    );

    modport slave (
        input  start, in_data, in_valid,
        output in_ready, ram_address, ram_data, ram_wren,
               done, invalid_char, byte_count
    );
endinterface

// File: rtl/decrypted_ram_writer.sv
// -----------------------------------------------------------------------------
// decrypted_ram_writer
// Takes decrypted message bytes one at a time over a valid/ready handshake and
// writes them to consecutive RAM addresses starting at 0. Every byte is checked
// against the plaintext alphabet (space, 'a'..'z'); the first illegal byte is
// still written (so it can be inspected) and then the run stops early with
// invalid_char set, letting the key-search controller move to the next key.
//
// Ports:
//   clk_i   system clock
//   rst_i   asynchronous, active-high reset
//   bus     decrypted_ram_writer_if.slave (stream in, RAM write port, status)
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | after reset, waiting for start
// WAIT  | in_ready=1, waiting for a byte from the datapath
// WRITE | ram_wren=1 for exactly one cycle, byte counted, next step chosen
// DONE  | run finished, done=1 held until the next start
// -----------------------------------------------------------------------------
module decrypted_ram_writer #(
    parameter int MSG_LENGTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input logic                    clk_i,
    input logic                    rst_i,
    decrypted_ram_writer_if.slave  bus
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_DATA = 2'd1;
    localparam logic [1:0] ST_WRITE     = 2'd2;
    localparam logic [1:0] ST_DONE      = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MSG_LENGTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);

    localparam logic [DATA_WIDTH-1:0] CH_SPACE = DATA_WIDTH'(8'h20);
    localparam logic [DATA_WIDTH-1:0] CH_LO_A  = DATA_WIDTH'(8'h61);
    localparam logic [DATA_WIDTH-1:0] CH_LO_Z  = DATA_WIDTH'(8'h7A);

    logic [1:0]            state_q,       state_d;
    logic [ADDR_WIDTH-1:0] addr_cnt_q,    addr_cnt_d;
    logic [ADDR_WIDTH-1:0] ram_address_q, ram_address_d;
    logic [DATA_WIDTH-1:0] ram_data_q,    ram_data_d;
    logic                  ram_wren_q,    ram_wren_d;
    logic                  legal_q,       legal_d;
    logic                  done_q,        done_d;
    logic                  invalid_q,     invalid_d;
    logic [ADDR_WIDTH:0]   byte_count_q,  byte_count_d;

    logic                  byte_legal;

    assign byte_legal = (bus.in_data == CH_SPACE) ||
                        ((bus.in_data >= CH_LO_A) && (bus.in_data <= CH_LO_Z));

    always_comb begin
        state_d       = state_q;
        addr_cnt_d    = addr_cnt_q;
        ram_address_d = ram_address_q;
        ram_data_d    = ram_data_q;
        ram_wren_d    = 1'b0;
        legal_d       = legal_q;
        done_d        = done_q;
        invalid_d     = invalid_q;
        byte_count_d  = byte_count_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    addr_cnt_d   = '0;
                    byte_count_d = '0;
                    invalid_d    = 1'b0;
                    done_d       = 1'b0;
                    state_d      = ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: begin
                // in_ready is 1 throughout this state, so in_valid alone
                // marks the transfer.
                if (bus.in_valid) begin
                    ram_data_d    = bus.in_data;
                    ram_address_d = addr_cnt_q;
                    ram_wren_d    = 1'b1;
                    legal_d       = byte_legal;
                    state_d       = ST_WRITE;
                end
            end
            ST_WRITE: begin
                byte_count_d = byte_count_q + CNT_ONE;
                if (!legal_q) begin
                    invalid_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = ST_DONE;
                end else if (addr_cnt_q == LAST_ADDR) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    addr_cnt_d = addr_cnt_q + ADDR_ONE;
                    state_d    = ST_WAIT_DATA;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            addr_cnt_q    <= '0;
            ram_address_q <= '0;
            ram_data_q    <= '0;
            ram_wren_q    <= 1'b0;
            legal_q       <= 1'b0;
            done_q        <= 1'b0;
            invalid_q     <= 1'b0;
            byte_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            addr_cnt_q    <= addr_cnt_d;
            ram_address_q <= ram_address_d;
            ram_data_q    <= ram_data_d;
            ram_wren_q    <= ram_wren_d;
            legal_q       <= legal_d;
            done_q        <= done_d;
            invalid_q     <= invalid_d;
            byte_count_q  <= byte_count_d;
        end
    end

    assign bus.in_ready     = (state_q == ST_WAIT_DATA);
    assign bus.ram_address  = ram_address_q;
    assign bus.ram_data     = ram_data_q;
    assign bus.ram_wren     = ram_wren_q;
    assign bus.done         = done_q;
    assign bus.invalid_char = invalid_q;
    assign bus.byte_count   = byte_count_q;

endmodule

// File: tb/tb_decrypted_ram_writer.sv
module tb_decrypted_ram_writer;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int ML = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decrypted_ram_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    decrypted_ram_writer #(.MSG_LENGTH(ML), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            first;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        mon_e;
    int         checks   = 0;
    int         failures = 0;
    longint     cycle    = 0;
    longint     last_wr_cycle = 0;
    bit         check_spacing = 0;
    bit         prev_accept   = 0;
    logic [7:0] msg[ML];

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(posedge clk) cycle++;

    // Monitor: every RAM write must match the next expected write, and must
    // follow an accepted handshake in the previous cycle.
    always @(negedge clk) begin
        if (!rst && bus.ram_wren) begin
            check("wren_after_accept", {31'd0, prev_accept}, 32'd1);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                         bus.ram_address, bus.ram_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", {24'd0, bus.ram_address}, {24'd0, mon_e.addr});
                check("wr_data", {24'd0, bus.ram_data}, {24'd0, mon_e.data});
                if (check_spacing && !mon_e.first)
                    check("wr_spacing", 32'(cycle - last_wr_cycle), 32'd2);
            end
            last_wr_cycle = cycle;
        end
        prev_accept = !rst && bus.in_valid && bus.in_ready;
    end

    // Reference model: plaintext alphabet is space and 'a'..'z'.
    function automatic bit is_legal(logic [7:0] b);
        return (b == 8'h20) || (b >= 8'h61 && b <= 8'h7A);
    endfunction

    // Bytes written = up to and including the first illegal byte, else ML.
    function automatic int model_count();
        for (int i = 0; i < ML; i++)
            if (!is_legal(msg[i])) return i + 1;
        return ML;
    endfunction

    task automatic load_abc();
        for (int i = 0; i < ML; i++) begin
            if (i < 26)       msg[i] = 8'h61 + 8'(i);
            else if (i == 26) msg[i] = 8'h20;
            else              msg[i] = 8'h61 + 8'(i - 27);
        end
    endtask

    task automatic load_random_legal();
        int r;
        for (int i = 0; i < ML; i++) begin
            r = $urandom_range(0, 26);
            msg[i] = (r == 26) ? 8'h20 : 8'h61 + 8'(r);
        end
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_wren"},  {31'd0, bus.ram_wren}, 32'd0);
        check({tag, "_ready"}, {31'd0, bus.in_ready}, 32'd0);
        check({tag, "_done"},  {31'd0, bus.done}, 32'd0);
        check({tag, "_inv"},   {31'd0, bus.invalid_char}, 32'd0);
        check({tag, "_count"}, {23'd0, bus.byte_count}, 32'd0);
        check({tag, "_addr"},  {24'd0, bus.ram_address}, 32'd0);
        check({tag, "_data"},  {24'd0, bus.ram_data}, 32'd0);
    endtask

    task automatic send_byte(logic [7:0] b, int gap);
        bit got = 0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk);
            if (bus.in_ready) got = 1;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 within 100 cycles");
        end
    endtask

    // One run: start, feed bytes as the model predicts, check final status.
    // start_at: index before which a stray start is pulsed (-1 none).
    // reset_at: index whose WRITE cycle gets a reset (-1 none).
    task automatic run(int start_at, int max_gap, bit spacing, int reset_at);
        int  n;
        bit  seen_done;
        wr_t e;
        n = model_count();
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            e.addr  = AW'(i);
            e.data  = msg[i];
            e.first = (i == 0);
            exp_q.push_back(e);
        end
        check_spacing = spacing;

        @(posedge clk);
        #1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("start_clr_done",  {31'd0, bus.done}, 32'd0);
        check("start_clr_inv",   {31'd0, bus.invalid_char}, 32'd0);
        check("start_clr_count", {23'd0, bus.byte_count}, 32'd0);

        for (int i = 0; i < n; i++) begin
            if (i == start_at) begin
                @(posedge clk);
                #1;
                bus.start = 1'b1;
                @(posedge clk);
                #1;
                bus.start = 1'b0;
            end
            send_byte(msg[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
            if (i == reset_at) begin
                check("wren_in_write", {31'd0, bus.ram_wren}, 32'd1);
                rst = 1'b1;
                exp_q.delete();
                #1;
                check_all_zero("midrst");
                repeat (2) @(posedge clk);
                #1;
                rst = 1'b0;
                return;
            end
        end

        seen_done = 0;
        for (int t = 0; t < 20 && !seen_done; t++) begin
            @(negedge clk);
            seen_done = bus.done;
        end
        check("done",         {31'd0, bus.done}, 32'd1);
        check("invalid_char", {31'd0, bus.invalid_char}, {31'd0, !is_legal(msg[n-1])});
        check("byte_count",   {23'd0, bus.byte_count}, 32'(n));
        check("writes_left",  32'(exp_q.size()), 32'd0);

        // A byte offered after the run ends must not be consumed.
        bus.in_data  = 8'h61;
        bus.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("ready_after_done", {31'd0, bus.in_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] bad[3];
        bad[0] = 8'h1F;
        bad[1] = 8'h60;
        bad[2] = 8'h7B;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        load_abc();
        run(-1, 0, 1, -1);

        load_abc();
        msg[5] = 8'h41;
        run(-1, 0, 1, -1);

        for (int k = 0; k < 3; k++) begin
            load_random_legal();
            run(-1, 5, 0, -1);
        end

        load_abc();
        msg[0] = 8'h20;
        msg[1] = 8'h61;
        msg[2] = 8'h7A;
        run(-1, 0, 1, -1);
        for (int k = 0; k < 3; k++) begin
            load_abc();
            msg[3 + k] = bad[k];
            run(-1, 0, 1, -1);
        end

        load_abc();
        run(-1, 0, 1, 10);
        load_abc();
        run(-1, 0, 1, -1);

        load_abc();
        run(7, 0, 0, -1);

        for (int k = 0; k < 3; k++) begin
            load_random_legal();
            msg[$urandom_range(0, ML - 1)] = 8'($urandom_range(0, 255));
            run(-1, 3, 0, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decrypted_ram_writer.md
Name: decrypted_ram_writer

Overview:
- Write-side counterpart of the encrypted-ROM read path.
- Accepts decrypted message bytes one at a time from the RC4 decrypt datapath over a valid/ready handshake and writes them sequentially into the on-chip decrypted-data RAM (address / data / wren port).
- Checks every byte against the legal plaintext alphabet and aborts early on the first illegal byte, so the key-search controller can move on to the next key.
- Reports completion and pass/fail to that controller.

Parameters:
- MSG_LENGTH, 32, number of message bytes written per run; legal range 1..256.
- ADDR_WIDTH, 8, width of the RAM address port.
- DATA_WIDTH, 8, width of the data path.

Ports:
- clk  input  1  system clock; CLOCK_50 at top level.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin a run; sampled only in IDLE and DONE.
- in_data  input  DATA_WIDTH  decrypted byte from the decrypt datapath.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  writer accepts in_data this cycle.
- ram_address  output  ADDR_WIDTH  RAM write address.
- ram_data  output  DATA_WIDTH  RAM write data.
- ram_wren  output  1  RAM write enable, one-cycle pulse per byte.
- done  output  1  run finished; held high until the next start.
- invalid_char  output  1  an illegal byte was seen in this run; valid while done=1.
- byte_count  output  ADDR_WIDTH+1  number of bytes written in the current or last run.

Behaviour:
- Reset (asynchronous, active-high, effective mid-operation): state=IDLE, in_ready=0, ram_wren=0, ram_address=0, ram_data=0, done=0, invalid_char=0, byte_count=0. Any write in flight is dropped with no partial pulse after reset asserts.
- All outputs are registered. Outputs other than in_ready are driven by flops. in_ready is decoded from the state register (1 only in WAIT_DATA).
- States:
  - IDLE: in_ready=0. On start=1, clear byte_count and invalid_char, set address counter to 0, go to WAIT_DATA.
  - WAIT_DATA: in_ready=1. A transfer occurs when in_valid=1 and in_ready=1. On a transfer:
    - latch ram_data<=in_data and ram_address<=address counter;
    - set ram_wren<=1;
    - register legal=(in_data==8'h20) or (8'h61<=in_data<=8'h7A);
    - go to WRITE.
    - With no transfer, hold.
  - WRITE (exactly one cycle): ram_wren=1, in_ready=0, byte_count increments by 1. Next:
    - byte illegal: invalid_char<=1, go to DONE;
    - address counter==MSG_LENGTH-1: go to DONE;
    - otherwise: address counter+1, go to WAIT_DATA.
  - DONE: done=1, ram_wren=0, in_ready=0. On start=1, clear done, byte_count and invalid_char; address counter=0; go to WAIT_DATA. The cleared outputs are visible the cycle after start.
- Illegal bytes are still written to RAM before aborting, so the failing byte is visible for debug.
- Throughput: at most one byte per 2 clocks. Latency from the accepting cycle to ram_wren=1 is 1 cycle. done rises 1 cycle after the final WRITE cycle.
- start in WAIT_DATA or WRITE is ignored; no restart mid-run.
- in_valid while in_ready=0 is not consumed. The producer must hold in_data and in_valid until accepted.
- Address counter never wraps within a run. With MSG_LENGTH=256, the final address is 255 and byte_count reaches 256, hence the ADDR_WIDTH+1 width.
- ram_address and ram_data hold their last values outside WRITE; only ram_wren qualifies a write.

Test Plan:
- Reset, start pulse, then feed 32 bytes "abcdefghijklmnopqrstuvwxyz abcde" with in_valid held high → 32 ram_wren pulses at addresses 0..31 with matching data, spaced 2 clocks apart; done=1, invalid_char=0, byte_count=32; RAM model contents match.
- Same stream but byte 5 = 8'h41 ('A') → 6 writes (addresses 0..5, address 5 holds 8'h41); done=1, invalid_char=1, byte_count=6; in_ready stays 0 afterwards.
- Random in_valid gaps of 0..5 cycles over 32 legal bytes → no byte lost or duplicated; each write occurs only after an accepted handshake; done=1.
- Boundary characters 8'h20, 8'h61, 8'h7A accepted; 8'h1F, 8'h60, 8'h7B each flagged invalid in separate runs, each restarted from DONE with start → invalid_char and byte_count cleared on each restart.
- Assert reset during the byte-10 WRITE cycle → ram_wren drops immediately, all outputs 0, state IDLE; a new start with 32 legal bytes writes addresses from 0 and completes normally.
- start pulsed while in WAIT_DATA at byte 7 → ignored; address sequence continues at 7; run completes with byte_count=32.
